// File: rtl/pipeline_interlock.sv
// pipeline_interlock: scoreboard-based RAW hazard interlock sitting beside the
// S1 decode stage. A small shift-register tracker follows the destination of
// every instruction in flight from S2 to writeback. S1 is stalled and a bubble
// is injected into S2 while an S1 source register is still pending.

module pipeline_interlock #(
    parameter int PIPE_DEPTH = 3,   // stages after S1 up to and including writeback (1..8)
    parameter int RF_BYPASS  = 1,   // 1 = regfile write-before-read, writeback entry not checked
    parameter int CNT_W      = 16   // width of Stall_Count
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             S1_Valid,
    input  logic [4:0]       S1_RS1,
    input  logic [4:0]       S1_RS2,
    input  logic             S1_UsesRS2,
    input  logic [4:0]       S1_WS,
    input  logic             S1_WE,
    input  logic             Flush,
    output logic             Stall,
    output logic             Bubble,
    output logic [CNT_W-1:0] Stall_Count
);

    // Number of tracker stages whose pending write can still be missed by an
    // S1 read; the writeback stage is excluded when the regfile bypasses.
    localparam int CHK_DEPTH = PIPE_DEPTH - RF_BYPASS;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Tracker entry k describes the instruction k+1 stages past S1.
    logic       trk_v_q  [PIPE_DEPTH];
    logic       trk_v_d  [PIPE_DEPTH];
    logic       trk_we_q [PIPE_DEPTH];
    logic       trk_we_d [PIPE_DEPTH];
    logic [4:0] trk_ws_q [PIPE_DEPTH];
    logic [4:0] trk_ws_d [PIPE_DEPTH];

    logic             hazard_s;
    logic             stall_s;
    logic             bubble_s;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A tracked entry blocks a read of register r when it is a real, writing
    // instruction whose destination is r; R0 is hardwired and never blocks.
    function automatic logic match_f(
        input logic       v,
        input logic       we,
        input logic [4:0] ws,
        input logic [4:0] r
    );
        match_f = v & we & (ws != 5'd0) & (ws == r);
    endfunction

    // Hazard detection: compare both S1 sources against every checked stage.
    always_comb begin
        hazard_s = 1'b0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            if (k < CHK_DEPTH) begin
                if (match_f(trk_v_q[k], trk_we_q[k], trk_ws_q[k], S1_RS1) ||
                    (S1_UsesRS2 && match_f(trk_v_q[k], trk_we_q[k], trk_ws_q[k], S1_RS2))) begin
                    hazard_s = 1'b1;
                end else begin
                    hazard_s = hazard_s;
                end
            end else begin
                hazard_s = hazard_s;
            end
        end
        hazard_s = hazard_s & S1_Valid;
    end

    // Stall/bubble decision: flush wins over a hazard, reset suppresses both.
    always_comb begin
        stall_s  = 1'b0;
        bubble_s = 1'b0;
        if (rst) begin
            stall_s  = 1'b0;
            bubble_s = 1'b0;
        end else begin
            stall_s  = hazard_s & ~Flush;
            bubble_s = stall_s | Flush;
        end
    end

    // Tracker next state: stage 0 takes S1 (or a bubble), older stages shift.
    always_comb begin
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            trk_v_d[k]  = 1'b0;
            trk_we_d[k] = 1'b0;
            trk_ws_d[k] = 5'd0;
        end
        if (stall_s || Flush) begin
            trk_v_d[0]  = 1'b0;
            trk_we_d[0] = 1'b0;
            trk_ws_d[0] = 5'd0;
        end else begin
            trk_v_d[0]  = S1_Valid;
            trk_we_d[0] = S1_WE & S1_Valid;
            trk_ws_d[0] = S1_WS;
        end
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            trk_v_d[k]  = trk_v_q[k-1];
            trk_we_d[k] = trk_we_q[k-1];
            trk_ws_d[k] = trk_ws_q[k-1];
        end
    end

    // Stall counter next state: count stall cycles, saturate at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (stall_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Tracker and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                trk_v_q[k]  <= 1'b0;
                trk_we_q[k] <= 1'b0;
                trk_ws_q[k] <= 5'd0;
            end
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                trk_v_q[k]  <= trk_v_d[k];
                trk_we_q[k] <= trk_we_d[k];
                trk_ws_q[k] <= trk_ws_d[k];
            end
            cnt_q <= cnt_d;
        end
    end

    assign Stall       = stall_s;
    assign Bubble      = bubble_s;
    assign Stall_Count = cnt_q;

    pipeline_interlock_chk u_chk (
        .clk      (clk),
        .rst      (rst),
        .flush_i  (Flush),
        .stall_i  (Stall),
        .bubble_i (Bubble)
    );

endmodule

// Protocol checks on the interlock outputs.
module pipeline_interlock_chk (
    input logic clk,
    input logic rst,
    input logic flush_i,
    input logic stall_i,
    input logic bubble_i
);

    a_bubble_def: assert property (@(posedge clk) disable iff (rst)
        bubble_i == (stall_i | flush_i));

    a_flush_prio: assert property (@(posedge clk) disable iff (rst)
        flush_i |-> !stall_i);

    a_rst_quiet: assert property (@(posedge clk)
        rst |-> (!stall_i && !bubble_i));

endmodule

// File: tb/tb_pipeline_interlock.sv
// Directed bench for pipeline_interlock: a per-cycle vector table for the
// single-hazard scenarios plus hand sequences for flush, reset and saturation.

module tb_pipeline_interlock;

    logic        clk;
    logic        rst;
    logic        s1_valid;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic        s1_uses_rs2;
    logic [4:0]  s1_ws;
    logic        s1_we;
    logic        flush;
    logic        stall;
    logic        bubble;
    logic [15:0] cnt;
    logic        stall_b;
    logic        bubble_b;
    logic [3:0]  cnt_b;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic        fl;
        logic        va;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  ws;
        logic        we;
        logic        es;
        logic        eb;
        int          ec;
    } vec_t;

    vec_t tbl[$];

    pipeline_interlock #(.PIPE_DEPTH(3), .RF_BYPASS(1), .CNT_W(16)) dut (
        .clk (clk), .rst (rst), .S1_Valid (s1_valid), .S1_RS1 (s1_rs1),
        .S1_RS2 (s1_rs2), .S1_UsesRS2 (s1_uses_rs2), .S1_WS (s1_ws),
        .S1_WE (s1_we), .Flush (flush), .Stall (stall), .Bubble (bubble),
        .Stall_Count (cnt)
    );

    pipeline_interlock #(.PIPE_DEPTH(3), .RF_BYPASS(1), .CNT_W(4)) dut_sat (
        .clk (clk), .rst (rst), .S1_Valid (s1_valid), .S1_RS1 (s1_rs1),
        .S1_RS2 (s1_rs2), .S1_UsesRS2 (s1_uses_rs2), .S1_WS (s1_ws),
        .S1_WE (s1_we), .Flush (flush), .Stall (stall_b), .Bubble (bubble_b),
        .Stall_Count (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic fl, input logic va, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic u2, input logic [4:0] ws,
                                input logic we, input logic es, input logic eb, input int ec);
        vec_t v;
        v.fl = fl; v.va = va; v.rs1 = rs1; v.rs2 = rs2; v.u2 = u2;
        v.ws = ws; v.we = we; v.es = es; v.eb = eb; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic fl, input logic va, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] ws,
                         input logic we);
        rst = r; flush = fl; s1_valid = va; s1_rs1 = rs1; s1_rs2 = rs2;
        s1_uses_rs2 = u2; s1_ws = ws; s1_we = we;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_c;
        int exp_s;
        n_cmp  = 0;
        n_fail = 0;

        apply(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        chk("rst_stall", int'(stall), 0);
        chk("rst_bubble", int'(bubble), 0);
        tick();
        tick();

        // fl va rs1 rs2 u2 ws we | stall bubble count
        tbl.push_back(mk(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 0)); // 0 I0 w5
        tbl.push_back(mk(1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 0)); // 1 I1 r5
        tbl.push_back(mk(1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1));
        tbl.push_back(mk(1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2)); // accepted
        tbl.push_back(mk(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2));
        tbl.push_back(mk(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 2)); // 5 w0
        tbl.push_back(mk(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2)); //   r0
        tbl.push_back(mk(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 2)); // 7 ws7 we0
        tbl.push_back(mk(1'b0, 1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2));
        tbl.push_back(mk(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 2)); // 9 w9
        tbl.push_back(mk(1'b0, 1'b1, 5'd1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2)); //   rs2 unused
        tbl.push_back(mk(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 2)); // 11 w9
        tbl.push_back(mk(1'b0, 1'b1, 5'd1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 2)); //   rs2 used
        tbl.push_back(mk(1'b0, 1'b1, 5'd1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 3));
        tbl.push_back(mk(1'b0, 1'b1, 5'd1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 4));
        tbl.push_back(mk(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 4)); // 15 w3
        tbl.push_back(mk(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4)); //   nop
        tbl.push_back(mk(1'b0, 1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 4)); //   r3 gap1
        tbl.push_back(mk(1'b0, 1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5));
        tbl.push_back(mk(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 5)); // 19 w3
        tbl.push_back(mk(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5));
        tbl.push_back(mk(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5));
        tbl.push_back(mk(1'b0, 1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5)); //   r3 gap2
        tbl.push_back(mk(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5)); // 23 flush only
        tbl.push_back(mk(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 5)); // 24 w4
        tbl.push_back(mk(1'b0, 1'b0, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5)); //   invalid r4
        tbl.push_back(mk(1'b0, 1'b1, 5'd0, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 5)); //   rs2 vs stage 2
        tbl.push_back(mk(1'b0, 1'b1, 5'd0, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 6));
        tbl.push_back(mk(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(1'b0, tbl[i].fl, tbl[i].va, tbl[i].rs1, tbl[i].rs2, tbl[i].u2,
                  tbl[i].ws, tbl[i].we);
            chk($sformatf("vec%0d_stall", i), int'(stall), int'(tbl[i].es));
            chk($sformatf("vec%0d_bubble", i), int'(bubble), int'(tbl[i].eb));
            chk($sformatf("vec%0d_count", i), int'(cnt), tbl[i].ec);
            tick();
        end

        // Flush in the first stall cycle: no stall, bubble, flushed write never tracked.
        apply(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1);
        chk("fl_prod_stall", int'(stall), 0);
        tick();
        apply(1'b0, 1'b1, 1'b1, 5'd5, 5'd0, 1'b0, 5'd6, 1'b1);
        chk("fl_stall", int'(stall), 0);
        chk("fl_bubble", int'(bubble), 1);
        tick();
        apply(1'b0, 1'b0, 1'b1, 5'd6, 5'd5, 1'b0, 5'd0, 1'b0);
        chk("fl_trk1_empty", int'(stall), 0);
        chk("fl_next_bubble", int'(bubble), 0);
        chk("fl_count", int'(cnt), 6);
        tick();
        apply(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        chk("fl_count_after", int'(cnt), 6);
        tick();

        // Reset in the middle of a stall.
        apply(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1);
        tick();
        apply(1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
        chk("rs_pre_stall", int'(stall), 1);
        tick();
        apply(1'b1, 1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
        chk("rs_mid_stall", int'(stall), 0);
        chk("rs_mid_bubble", int'(bubble), 0);
        chk("rs_mid_count", int'(cnt), 7);
        tick();
        apply(1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
        chk("rs_first_instr", int'(stall), 0);
        chk("rs_count_clr", int'(cnt), 0);
        chk("rs_count_clr_sat", int'(cnt_b), 0);
        tick();
        apply(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();

        // Saturation: eleven producer/consumer pairs, two stall cycles each.
        exp_c = 0;
        exp_s = 0;
        for (int p = 0; p < 11; p++) begin
            apply(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1);
            chk($sformatf("sat%0d_prod", p), int'(stall), 0);
            tick();
            for (int j = 0; j < 3; j++) begin
                apply(1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
                chk($sformatf("sat%0d_%0d_stall", p, j), int'(stall), (j < 2) ? 1 : 0);
                chk($sformatf("sat%0d_%0d_stall4", p, j), int'(stall_b), (j < 2) ? 1 : 0);
                chk($sformatf("sat%0d_%0d_cnt", p, j), int'(cnt), exp_c);
                chk($sformatf("sat%0d_%0d_cnt4", p, j), int'(cnt_b), exp_s);
                tick();
                if (j < 2) begin
                    exp_c = exp_c + 1;
                    exp_s = (exp_s < 15) ? exp_s + 1 : 15;
                end
            end
        end
        apply(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        chk("sat_final_cnt", int'(cnt), 22);
        chk("sat_final_cnt4", int'(cnt_b), 15);
        tick();
        chk("sat_hold_cnt4", int'(cnt_b), 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
